// File: rtl/hwpe_ctrl_reqrsp_initiator_if.sv
// hwpe_ctrl_intf_reqrsp: request/response bus between a reqrsp initiator
// and a reqrsp target (register peripheral).
//   q_*   : request channel (addr, write, data, strb) with valid/ready
//   p_*   : response channel (data) with valid/ready
// Modports: initiator/master drive q_* and p_ready; target/slave the rest.
interface hwpe_ctrl_intf_reqrsp #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
) ();
    logic [AW-1:0]   q_addr;
    logic            q_write;
    logic [DW-1:0]   q_data;
    logic [DW/8-1:0] q_strb;
    logic            q_valid;
    logic            q_ready;
    logic            p_valid;
    logic [DW-1:0]   p_data;
    logic            p_ready;

    modport initiator (
        output q_addr, q_write, q_data, q_strb, q_valid, p_ready,
        input  q_ready, p_valid, p_data
    );
    modport target (
        input  q_addr, q_write, q_data, q_strb, q_valid, p_ready,
        output q_ready, p_valid, p_data
    );
    modport master (
        output q_addr, q_write, q_data, q_strb, q_valid, p_ready,
        input  q_ready, p_valid, p_data
    );
    modport slave (
        input  q_addr, q_write, q_data, q_strb, q_valid, p_ready,
        output q_ready, p_valid, p_data
    );
endinterface

// File: rtl/hwpe_ctrl_reqrsp_initiator.sv
// hwpe_ctrl_reqrsp_initiator: turns register-access commands into reqrsp
// requests, keeps at most MAX_OUTSTANDING commands in flight, drops write
// responses and returns read data in order. clear_i drains in-flight traffic.
// Ports:
//   clk_i, rst_ni (async, active low), clear_i (sync soft clear)
//   cmd_*  : command stream in (valid/ready, write, addr, wdata, strb)
//   rsp_*  : read-data stream out (valid/ready, rdata)
//   cfg    : reqrsp initiator bus
//   busy_o : traffic in flight or draining; timeout_o : sticky timeout flag
// Optional: define HWPE_CTRL_REQRSP_INITIATOR_TIMEOUT_EN to build the
// response timeout counter; otherwise timeout_o is tied low.
module hwpe_ctrl_reqrsp_initiator #(
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [AW-1:0]         cmd_addr_i,
    input  logic [DW-1:0]         cmd_wdata_i,
    input  logic [DW/8-1:0]       cmd_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DW-1:0]         rsp_rdata_o,
    hwpe_ctrl_intf_reqrsp.initiator cfg,
    output logic                  busy_o,
    output logic                  timeout_o
);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]                 state_q;
    logic [CW-1:0]              inflight_q, inflight_d;
    logic [MAX_OUTSTANDING-1:0] type_q;     // 1 = write, one entry per in-flight command
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;

    logic            q_valid_q, q_write_q;
    logic [AW-1:0]   q_addr_q;
    logic [DW-1:0]   q_data_q;
    logic [DW/8-1:0] q_strb_q;

    logic fifo_empty, head_write, rsp_sel, p_hs, q_hs, accept;

    assign fifo_empty = (inflight_q == '0);
    assign head_write = type_q[rd_ptr_q];
    // Read data is forwarded only in RUN with a read at the FIFO head;
    // everything else the initiator consumes itself.
    assign rsp_sel    = (state_q == ST_RUN) && !fifo_empty && !head_write;

    // Empty FIFO keeps p_ready low so a stray response is never swallowed.
    assign cfg.p_ready = fifo_empty ? 1'b0 : (rsp_sel ? rsp_ready_i : 1'b1);
    assign rsp_valid_o = rsp_sel & cfg.p_valid;
    assign rsp_rdata_o = rsp_sel ? cfg.p_data : '0;

    assign p_hs = cfg.p_valid & cfg.p_ready;
    assign q_hs = q_valid_q & cfg.q_ready;

    // A response retiring this cycle frees a slot for a new command.
    assign cmd_ready_o = rst_ni && (state_q == ST_RUN) && (!q_valid_q || cfg.q_ready)
                         && ((inflight_q < MAX_CNT) || p_hs);
    assign accept      = cmd_valid_i & cmd_ready_o;

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !p_hs)      inflight_d = inflight_q + 1'b1;
        else if (!accept && p_hs) inflight_d = inflight_q - 1'b1;
    end

    assign busy_o = (inflight_q != '0) || (state_q == ST_DRAIN);

    assign cfg.q_valid = q_valid_q;
    assign cfg.q_write = q_write_q;
    assign cfg.q_addr  = q_addr_q;
    assign cfg.q_data  = q_data_q;
    assign cfg.q_strb  = q_strb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_valid_q <= 1'b0;
            q_write_q <= 1'b0;
            q_addr_q  <= '0;
            q_data_q  <= '0;
            q_strb_q  <= '0;
        end else if (accept) begin
            q_valid_q <= 1'b1;
            q_write_q <= cmd_write_i;
            q_addr_q  <= cmd_addr_i;
            q_data_q  <= cmd_wdata_i;
            q_strb_q  <= cmd_write_i ? cmd_strb_i : '0;
        end else if (q_hs) begin
            q_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            inflight_q <= '0;
            type_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (accept) begin
                type_q[wr_ptr_q] <= cmd_write_i;
                wr_ptr_q         <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (p_hs)
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            case (state_q)
                ST_RUN:   if (clear_i && !fifo_empty) state_q <= ST_DRAIN;
                ST_DRAIN: if (inflight_d == '0)       state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

`ifdef HWPE_CTRL_REQRSP_INITIATOR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;
    logic          timeout_q;
    logic          clear_done;

    // A clear completes either immediately (nothing in flight) or when the
    // drain retires its last response.
    assign clear_done = ((state_q == ST_RUN) && clear_i && fifo_empty)
                     || ((state_q == ST_DRAIN) && (inflight_d == '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (fifo_empty || p_hs)
                to_cnt_q <= '0;
            else if (to_cnt_q != TW'(TIMEOUT_CYCLES))
                to_cnt_q <= to_cnt_q + 1'b1;
            if (clear_done)
                timeout_q <= 1'b0;
            else if (!fifo_empty && !p_hs && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)))
                timeout_q <= 1'b1;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_hwpe_ctrl_reqrsp_initiator.sv
module tb_hwpe_ctrl_reqrsp_initiator;
    logic        clk, rst_n, clear;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_strb;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_rdata;
    logic        busy, timeout;

    int vectors = 0;
    int miscompares = 0;
    int rsp_cnt = 0;
    int phs_cnt = 0;

    logic [63:0] exp_q[$];    // expected read data, in order
    logic [63:0] pdata_q[$];  // response data for accepted commands, in order
    logic [63:0] tgt_pend[$]; // issued requests awaiting a response
    bit tgt_en = 0;
    bit q_hs_seen = 0, p_hs_seen = 0;

    hwpe_ctrl_intf_reqrsp #(.AW(32), .DW(64)) cfg ();

    hwpe_ctrl_reqrsp_initiator #(
        .AW(32), .DW(64), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .cfg(cfg), .busy_o(busy), .timeout_o(timeout)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Monitor: handshakes are observed at negedge and fire at the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg.q_valid && cfg.q_ready) q_hs_seen = 1;
            if (cfg.p_valid && cfg.p_ready) begin p_hs_seen = 1; phs_cnt++; end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: got %h want no response", rsp_rdata);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (rsp_rdata !== e) begin
                        miscompares++;
                        $display("FAIL rsp_data: got %h want %h", rsp_rdata, e);
                    end
                end
            end
        end
    end

    // Target model: answers issued requests in order, one per cycle when enabled.
    always begin
        @(posedge clk); #2;
        if (!rst_n) begin
            tgt_pend.delete();
            q_hs_seen = 0; p_hs_seen = 0;
        end else begin
            if (p_hs_seen && tgt_pend.size() > 0) void'(tgt_pend.pop_front());
            if (q_hs_seen && pdata_q.size() > 0) tgt_pend.push_back(pdata_q.pop_front());
            q_hs_seen = 0; p_hs_seen = 0;
        end
        cfg.p_valid = rst_n && tgt_en && (tgt_pend.size() > 0);
        cfg.p_data  = cfg.p_valid ? tgt_pend[0] : 64'h0;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] s, input logic [63:0] pd, input bit chk);
        bit ok = 0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                pdata_q.push_back(pd);
                if (!w && chk) exp_q.push_back(pd);
            end
            tick();
        end
        cmd_valid = 0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL send_accept: got cmd_ready 0 want 1 within 50 cycles");
        end
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
            tick();
        end
        vectors++;
        if (!idle) begin
            miscompares++;
            $display("FAIL %s_idle: got busy_o 1 want 0", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; clear = 0; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hFFFF_FFFF;
        cmd_wdata = '1; cmd_strb = '1; rsp_ready = 1; cfg.q_ready = 1;
        repeat (3) @(negedge clk);
        vectors += 6;
        if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        if ({cfg.q_valid, cfg.q_write} !== 2'b00) begin miscompares++; $display("FAIL rst_q_ctl: got %b want 00", {cfg.q_valid, cfg.q_write}); end
        if ({cfg.q_addr, cfg.q_data, cfg.q_strb} !== '0) begin miscompares++; $display("FAIL rst_q_fields: got %h want 0", {cfg.q_addr, cfg.q_data, cfg.q_strb}); end
        if (cfg.p_ready !== 1'b0) begin miscompares++; $display("FAIL rst_p_ready: got %b want 0", cfg.p_ready); end
        if ({rsp_valid, rsp_rdata} !== '0) begin miscompares++; $display("FAIL rst_rsp: got %h want 0", {rsp_valid, rsp_rdata}); end
        if ({busy, timeout} !== 2'b00) begin miscompares++; $display("FAIL rst_status: got %b want 00", {busy, timeout}); end
        cmd_valid = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_cmd_ready: got %b want 1", cmd_ready); end
        tick();
    endtask

    task automatic test_write();
        int qv = 0, rv = 0;
        tgt_en = 1; cfg.q_ready = 1; rsp_ready = 1;
        send(1'b1, 32'h20, 64'h12345678_9ABCDEF0, 8'hFF, 64'hDEAD, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                vectors++;
                if ({cfg.q_write, cfg.q_addr, cfg.q_data, cfg.q_strb} !== {1'b1, 32'h20, 64'h12345678_9ABCDEF0, 8'hFF}) begin
                    miscompares++;
                    $display("FAIL wr_q_fields: got %h want %h", {cfg.q_write, cfg.q_addr, cfg.q_data, cfg.q_strb},
                             {1'b1, 32'h20, 64'h12345678_9ABCDEF0, 8'hFF});
                end
            end
            if (cfg.q_valid) qv++;
            if (rsp_valid) rv++;
            tick();
        end
        vectors += 2;
        if (qv != 1) begin miscompares++; $display("FAIL wr_q_valid_cycles: got %0d want 1", qv); end
        if (rv != 0) begin miscompares++; $display("FAIL wr_rsp_valid: got %0d cycles want 0", rv); end
        wait_idle("wr");
    endtask

    task automatic test_read();
        bit seen = 0;
        tgt_en = 1; cfg.q_ready = 1; rsp_ready = 0;
        send(1'b0, 32'h10, 64'h0, 8'hFF, 64'h1, 1'b1);
        @(negedge clk);
        vectors++;
        if ({cfg.q_valid, cfg.q_write, cfg.q_addr, cfg.q_strb} !== {1'b1, 1'b0, 32'h10, 8'h00}) begin
            miscompares++;
            $display("FAIL rd_q_fields: got %h want %h", {cfg.q_valid, cfg.q_write, cfg.q_addr, cfg.q_strb}, {1'b1, 1'b0, 32'h10, 8'h00});
        end
        tick();
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
            if (!seen) tick();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL rd_rsp_valid: got 0 want 1 within 20 cycles"); end
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors += 2;
            if ({rsp_valid, rsp_rdata} !== {1'b1, 64'h1}) begin
                miscompares++; $display("FAIL rd_hold_%0d: got %b/%h want 1/1", i, rsp_valid, rsp_rdata);
            end
            if (cfg.p_ready !== 1'b0) begin miscompares++; $display("FAIL rd_p_ready_wait_%0d: got %b want 0", i, cfg.p_ready); end
            tick();
        end
        rsp_ready = 1;
        @(negedge clk);
        vectors++;
        if (cfg.p_ready !== 1'b1) begin miscompares++; $display("FAIL rd_p_ready: got %b want 1", cfg.p_ready); end
        tick();
        wait_idle("rd");
    endtask

    task automatic test_outstanding();
        int acc = 0;
        int r0;
        bit stall_ok;
        tgt_en = 0; cfg.q_ready = 1; rsp_ready = 1;
        r0 = rsp_cnt;
        cmd_write = 0; cmd_strb = 0; cmd_wdata = 0; cmd_valid = 1;
        for (int c = 0; c < 8; c++) begin
            cmd_addr = 32'h100 + 32'(acc * 8);
            @(negedge clk);
            if (cmd_ready) begin pdata_q.push_back(64'h100 + 64'(acc)); exp_q.push_back(64'h100 + 64'(acc)); acc++; end
            tick();
        end
        @(negedge clk);
        stall_ok = (cmd_ready == 1'b0);
        vectors += 2;
        if (acc != 4) begin miscompares++; $display("FAIL os_accepted: got %0d want 4", acc); end
        if (!stall_ok) begin miscompares++; $display("FAIL os_stall: got cmd_ready %b want 0", cmd_ready); end
        tick();
        tgt_en = 1;
        cmd_addr = 32'h100 + 32'(acc * 8);
        @(negedge clk);
        vectors++;
        if ({cmd_ready, cfg.p_ready} !== 2'b11) begin
            miscompares++; $display("FAIL os_reopen: got cmd_ready/p_ready %b want 11", {cmd_ready, cfg.p_ready});
        end
        if (cmd_ready) begin pdata_q.push_back(64'h100 + 64'(acc)); exp_q.push_back(64'h100 + 64'(acc)); acc++; end
        tick();
        for (int c = 0; c < 20 && acc < 6; c++) begin
            cmd_addr = 32'h100 + 32'(acc * 8);
            @(negedge clk);
            if (cmd_ready) begin pdata_q.push_back(64'h100 + 64'(acc)); exp_q.push_back(64'h100 + 64'(acc)); acc++; end
            tick();
        end
        cmd_valid = 0;
        wait_idle("os");
        vectors++;
        if (rsp_cnt - r0 != 6) begin miscompares++; $display("FAIL os_rsp_count: got %0d want 6", rsp_cnt - r0); end
    endtask

    task automatic test_interleave();
        int r0;
        tgt_en = 1; cfg.q_ready = 1; rsp_ready = 1;
        r0 = rsp_cnt;
        send(1'b1, 32'h0, 64'h1111, 8'h0F, 64'hA, 1'b0);
        send(1'b0, 32'h8, 64'h0,    8'h00, 64'hB, 1'b1);
        send(1'b1, 32'h10, 64'h2222, 8'hF0, 64'hC, 1'b0);
        send(1'b0, 32'h18, 64'h0,    8'h00, 64'hD, 1'b1);
        wait_idle("il");
        vectors += 2;
        if (rsp_cnt - r0 != 2) begin miscompares++; $display("FAIL il_rsp_count: got %0d want 2", rsp_cnt - r0); end
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL il_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_clear();
        int r0, p0, rv = 0;
        tgt_en = 0; cfg.q_ready = 1; rsp_ready = 1;
        send(1'b0, 32'h30, 64'h0, 8'h00, 64'h31, 1'b0);
        send(1'b0, 32'h38, 64'h0, 8'h00, 64'h32, 1'b0);
        send(1'b0, 32'h40, 64'h0, 8'h00, 64'h33, 1'b0);
        clear = 1;
        tick();
        clear = 0;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, busy} !== 2'b01) begin miscompares++; $display("FAIL clr_drain_state: got cmd_ready/busy %b want 01", {cmd_ready, busy}); end
        tick();
        r0 = rsp_cnt; p0 = phs_cnt;
        tgt_en = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) rv++;
            tick();
        end
        vectors += 3;
        if (rv != 0) begin miscompares++; $display("FAIL clr_rsp_valid: got %0d cycles want 0", rv); end
        if (phs_cnt - p0 != 3) begin miscompares++; $display("FAIL clr_consumed: got %0d want 3", phs_cnt - p0); end
        if (rsp_cnt != r0) begin miscompares++; $display("FAIL clr_rsp_count: got %0d want 0", rsp_cnt - r0); end
        @(negedge clk);
        vectors++;
        if ({cmd_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL clr_back_run: got cmd_ready/busy %b want 10", {cmd_ready, busy}); end
        tick();
        send(1'b0, 32'h48, 64'h0, 8'h00, 64'h44, 1'b1);
        wait_idle("clr");
        vectors++;
        if (rsp_cnt - r0 != 1) begin miscompares++; $display("FAIL clr_next_read: got %0d want 1", rsp_cnt - r0); end
    endtask

    task automatic test_timeout();
        tgt_en = 0; cfg.q_ready = 1; rsp_ready = 1;
        send(1'b0, 32'h50, 64'h0, 8'h00, 64'h77, 1'b1);
`ifdef HWPE_CTRL_REQRSP_INITIATOR_TIMEOUT_EN
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) begin
                vectors++;
                if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_early: got %b want 0", timeout); end
            end
            if (k == 16) begin
                vectors++;
                if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_set: got %b want 1", timeout); end
            end
            tick();
        end
        tgt_en = 1;
        wait_idle("to");
        @(negedge clk);
        vectors++;
        if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %b want 1", timeout); end
        tick();
        clear = 1;
        tick();
        clear = 0;
        @(negedge clk);
        vectors++;
        if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_cleared: got %b want 0", timeout); end
        tick();
`else
        repeat (20) tick();
        @(negedge clk);
        vectors++;
        if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_tied: got %b want 0", timeout); end
        tick();
        tgt_en = 1;
        wait_idle("to");
`endif
    endtask

    initial begin
        cfg.q_ready = 0;
        test_reset();
        test_write();
        test_read();
        test_outstanding();
        test_interleave();
        test_clear();
        test_timeout();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL final_pending: got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hwpe_ctrl_reqrsp_initiator.md
# hwpe_ctrl_reqrsp_initiator

Initiator (manager) side of the HWPE reqrsp control protocol: turns a stream of register-access commands into reqrsp requests and returns read data in order. It sits in front of an `hwpe_ctrl_reqrsp_target` peripheral, for example inside a cluster-side DMA/config sequencer or a bench-free self-test harness. It enforces a bounded number of in-flight requests, drops write responses internally and supports a draining soft clear.

## Interface
- AW, 32, request address width
- DW, 64, data width; strobe width is DW/8
- MAX_OUTSTANDING, 4, max accepted-but-unanswered commands (≥1, power of two)
- TIMEOUT_CYCLES, 1024, response timeout threshold (used only with the timeout feature)

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  AW  target address
- cmd_wdata_i  in  DW  write data
- cmd_strb_i  in  DW/8  write byte strobes
- rsp_valid_o / rsp_ready_i  out/in  1  read-data handshake
- rsp_rdata_o  out  DW  read data
- cfg  initiator modport  hwpe_ctrl_intf_reqrsp #(AW,DW)  drives q_addr/q_write/q_data/q_strb/q_valid and p_ready; samples q_ready/p_valid/p_data
- busy_o  out  1  in-flight ≠ 0 or state DRAIN
- timeout_o  out  1  sticky response-timeout flag

## Operation
- States: RUN and DRAIN. Reset enters RUN.
- Command acceptance requires all of the following:
  - state RUN;
  - the q output register is empty, or being consumed this cycle;
  - in-flight < MAX_OUTSTANDING, or a response handshake occurs this cycle.
- On accept:
  - load the q register (addr, write, data, strb; strb forced '0 for reads);
  - push cmd_write_i into a type FIFO of depth MAX_OUTSTANDING;
  - in-flight += 1.
- q_valid is held high until q_ready. All q fields stay stable while q_valid && !q_ready.
- Responses are strictly in order. The FIFO head selects the routing:
  - head = write: p_ready = 1, the response is discarded, rsp_valid_o stays 0;
  - head = read: rsp_valid_o = p_valid, rsp_rdata_o = p_data, p_ready = rsp_ready_i;
  - FIFO empty: p_ready = 0, and an unsolicited p_valid is never consumed.
- Response handshake: pop the FIFO, in-flight -= 1. An accept and a response in the same cycle leave in-flight unchanged.
- clear_i in RUN:
  - in-flight = 0: clears timeout_o and stays in RUN;
  - in-flight > 0: go to DRAIN.
- DRAIN:
  - cmd_ready_o = 0;
  - the pending q request is still issued;
  - p_ready = 1 for every response and all responses are discarded (rsp_valid_o = 0);
  - when in-flight reaches 0, clear timeout_o and return to RUN.
- clear_i while already in DRAIN has no additional effect.
- Async reset clears everything immediately. The peripheral must be reset together with this block.

## Timing
- Reset values: cmd_ready_o 0 during reset, q_valid 0, q_addr/q_data/q_strb 0, q_write 0, p_ready 0, rsp_valid_o 0, rsp_rdata_o 0, busy_o 0, timeout_o 0.
- Command → q_valid: 1 cycle (registered). With q_ready tied high, back-to-back accept gives one request per cycle.
- p channel → rsp channel: 0 cycles (combinational). rsp_valid_o and rsp_rdata_o follow p_valid and p_data.
- cmd_ready_o is combinational from registered state and from q_ready, p_valid and rsp_ready_i. It does not depend on cmd_valid_i.
- in-flight counter width is $clog2(MAX_OUTSTANDING+1). It never exceeds MAX_OUTSTANDING and never underflows.

## Configuration
- HWPE_CTRL_REQRSP_INITIATOR_TIMEOUT_EN defined:
  - a counter of width $clog2(TIMEOUT_CYCLES+1) increments each cycle with in-flight > 0 and no response handshake;
  - it resets to 0 on a response handshake or when in-flight = 0;
  - on reaching TIMEOUT_CYCLES it sets timeout_o, which stays set until reset or a clear completes;
  - the counter saturates.
- Not defined: no counter is built, timeout_o is tied 0, and TIMEOUT_CYCLES is ignored.

## Test plan
- Write 0x20 ← 64'h12345678_9ABCDEF0, q_ready high, p_valid one cycle later → q_valid for exactly 1 cycle with q_strb = 8'hFF; no rsp_valid_o; busy_o returns to 0.
- Read 0x10 with rsp_ready_i delayed 3 cycles after p_valid, p_data = 64'h1 → rsp_rdata_o = 64'h1 held stable; p_ready rises only with rsp_ready_i; q_strb = 0.
- 6 back-to-back reads, q_ready = 1, target withheld (p_valid = 0) → exactly 4 accepted (MAX_OUTSTANDING = 4), then cmd_ready_o = 0; the first response reopens acceptance in the same cycle.
- Interleaved W, R, W, R with p_data 0xA, 0xB, 0xC, 0xD → rsp port delivers only 0xB then 0xD, in order.
- clear_i with 3 requests in flight → DRAIN, cmd_ready_o = 0, 3 responses consumed with rsp_valid_o = 0, then back to RUN; the next read works.
- With the timeout macro and TIMEOUT_CYCLES = 16: read issued, no response → timeout_o rises on the 16th cycle; the late response still drains; clear_i then clears timeout_o.
